// File: rtl/alarm_pkg.sv
// Shared types and field widths for the alarm sequencer and its helpers.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_e;

    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int SEC_W     = 6;
    localparam int SEC_CNT_W = 9;
    localparam int SNZ_W     = 4;

endpackage

// File: rtl/alarm_trigger_btn_pulse.sv
// Push-button sampler: shifts the raw level in every clock and emits a single
// pulse when the newest sample is high and every older sample is low.
module btn_pulse #(
    parameter int DEB_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam logic [DEB_LEN-1:0] NEWEST_ONLY = {{(DEB_LEN-1){1'b0}}, 1'b1};

    logic [DEB_LEN-1:0] shift_q;
    logic [DEB_LEN-1:0] shift_d;

    // Next sample history: drop the oldest, append the raw level.
    always_comb begin
        shift_d = {shift_q[DEB_LEN-2:0], btn_i};
    end

    // Sample history register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q <= {DEB_LEN{1'b0}};
        end else begin
            shift_q <= shift_d;
        end
    end

    assign pulse_o = (shift_q == NEWEST_ONLY);

endmodule

// File: rtl/alarm_trigger.sv
// Alarm sequencer: fires on the alarm minute boundary, rings, snoozes a bounded
// number of times and auto-stops an unanswered ring.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int DEB_LEN    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1s,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              alarm_en,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    output logic              melody_sw,
    output logic              ringing,
    output logic              snoozing,
    output logic [SNZ_W-1:0]  snooze_cnt
);

    localparam logic [SEC_CNT_W-1:0] RING_LAST   = SEC_CNT_W'(RING_SEC - 1);
    localparam logic [SEC_CNT_W-1:0] SNOOZE_LAST = SEC_CNT_W'(SNOOZE_SEC - 1);
    localparam logic [SNZ_W-1:0]     SNZ_MAX     = SNZ_W'(MAX_SNOOZE);

    alarm_state_e         state_q, state_d;
    logic [SEC_CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [SNZ_W-1:0]     snooze_cnt_q, snooze_cnt_d;
    logic                 match_q;
    logic                 melody_q, ringing_q, snoozing_q;
    logic                 match_s, fire_s, stop_pulse_s, snooze_pulse_s;

    btn_pulse #(.DEB_LEN(DEB_LEN)) u_stop_pulse (
        .clk_i   (clk),
        .reset_i (reset),
        .btn_i   (stop_btn),
        .pulse_o (stop_pulse_s)
    );

    btn_pulse #(.DEB_LEN(DEB_LEN)) u_snooze_pulse (
        .clk_i   (clk),
        .reset_i (reset),
        .btn_i   (snooze_btn),
        .pulse_o (snooze_pulse_s)
    );

    // Match/fire decode; the rising edge of match keeps a held cur_sec==0 from re-firing.
    always_comb begin
        match_s = alarm_en & (cur_hour == alarm_hour) & (cur_min == alarm_min)
                  & (cur_sec == {SEC_W{1'b0}});
        fire_s  = match_s & ~match_q;
    end

    // Next-state logic; alarm_en low overrides stop, which overrides snooze, then ticks.
    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        if (!alarm_en) begin
            state_d      = ST_IDLE;
            sec_cnt_d    = {SEC_CNT_W{1'b0}};
            snooze_cnt_d = {SNZ_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire_s) begin
                        state_d      = ST_RING;
                        sec_cnt_d    = {SEC_CNT_W{1'b0}};
                        snooze_cnt_d = {SNZ_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RING: begin
                    if (stop_pulse_s) begin
                        state_d      = ST_IDLE;
                        snooze_cnt_d = {SNZ_W{1'b0}};
                    end else if (snooze_pulse_s && (snooze_cnt_q < SNZ_MAX)) begin
                        state_d      = ST_SNOOZE;
                        sec_cnt_d    = {SEC_CNT_W{1'b0}};
                        snooze_cnt_d = snooze_cnt_q + {{(SNZ_W-1){1'b0}}, 1'b1};
                    end else if (tick_1s && (sec_cnt_q == RING_LAST)) begin
                        state_d      = ST_IDLE;
                        snooze_cnt_d = {SNZ_W{1'b0}};
                    end else if (tick_1s) begin
                        sec_cnt_d = sec_cnt_q + {{(SEC_CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = ST_RING;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_pulse_s) begin
                        state_d      = ST_IDLE;
                        snooze_cnt_d = {SNZ_W{1'b0}};
                    end else if (tick_1s && (sec_cnt_q == SNOOZE_LAST)) begin
                        state_d   = ST_RING;
                        sec_cnt_d = {SEC_CNT_W{1'b0}};
                    end else if (tick_1s) begin
                        sec_cnt_d = sec_cnt_q + {{(SEC_CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = ST_SNOOZE;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    sec_cnt_d    = {SEC_CNT_W{1'b0}};
                    snooze_cnt_d = {SNZ_W{1'b0}};
                end
            endcase
        end
    end

    // State, counters and output registers; outputs are decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sec_cnt_q    <= {SEC_CNT_W{1'b0}};
            snooze_cnt_q <= {SNZ_W{1'b0}};
            match_q      <= 1'b0;
            melody_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            match_q      <= match_s;
            melody_q     <= (state_d == ST_RING);
            ringing_q    <= (state_d == ST_RING);
            snoozing_q   <= (state_d == ST_SNOOZE);
        end
    end

    assign melody_sw  = melody_q;
    assign ringing    = ringing_q;
    assign snoozing   = snoozing_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger: directed scenarios plus random stimulus,
// compared against a countdown-based behavioural model.
module tb_alarm_trigger;

    localparam int RING_SEC   = 5;
    localparam int SNOOZE_SEC = 3;
    localparam int MAX_SNOOZE = 2;
    localparam int DEB_LEN    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1s = 1'b0;
    logic [4:0] cur_hour = 5'd0;
    logic [5:0] cur_min = 6'd0;
    logic [5:0] cur_sec = 6'd1;
    logic [4:0] alarm_hour = 5'd7;
    logic [5:0] alarm_min = 6'd30;
    logic       alarm_en = 1'b0;
    logic       stop_btn = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       melody_sw, ringing, snoozing;
    logic [3:0] snooze_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit tick_en = 1'b0;

    alarm_trigger #(
        .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNOOZE(MAX_SNOOZE), .DEB_LEN(DEB_LEN)
    ) dut (
        .clk(clk), .reset(reset), .tick_1s(tick_1s),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
        .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .melody_sw(melody_sw), .ringing(ringing), .snoozing(snoozing),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 ring, 2 snooze; m_left counts seconds remaining.
    int         m_mode = 0;
    int         m_left = 0;
    int         m_snz = 0;
    bit         m_match_prev = 1'b0;
    bit         m_match, m_fire, m_sp, m_zp;
    bit         stop_hist[$];
    bit         snz_hist[$];
    logic [6:0] exp_vec = 7'd0;

    function automatic bit is_press(input bit h[$]);
        if (h.size() == 0) return 1'b0;
        if (!h[0]) return 1'b0;
        for (int i = 1; i < h.size(); i++) if (h[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        m_match = alarm_en && (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
        m_sp = is_press(stop_hist);
        m_zp = is_press(snz_hist);
        if (reset) begin
            m_mode = 0; m_left = 0; m_snz = 0; m_match_prev = 1'b0;
            stop_hist = {}; snz_hist = {};
        end else begin
            m_fire = m_match && !m_match_prev;
            m_match_prev = m_match;
            stop_hist.push_front(stop_btn);
            snz_hist.push_front(snooze_btn);
            if (stop_hist.size() > DEB_LEN) void'(stop_hist.pop_back());
            if (snz_hist.size() > DEB_LEN) void'(snz_hist.pop_back());
            if (!alarm_en) begin
                m_mode = 0; m_snz = 0;
            end else if (m_mode == 0) begin
                if (m_fire) begin m_mode = 1; m_left = RING_SEC; m_snz = 0; end
            end else if (m_sp) begin
                m_mode = 0; m_snz = 0;
            end else if (m_mode == 1 && m_zp && m_snz < MAX_SNOOZE) begin
                m_mode = 2; m_left = SNOOZE_SEC; m_snz = m_snz + 1;
            end else if (tick_1s) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_mode == 1) begin m_mode = 0; m_snz = 0; end
                    else begin m_mode = 1; m_left = RING_SEC; end
                end
            end
        end
        exp_vec = {m_mode == 1, m_mode == 1, m_mode == 2, 4'(m_snz)};
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        tick_1s = tick_en && (cyc % 10 == 0);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    task automatic fire_alarm();
        set_time(7, 29, 59); cycle();
        set_time(7, 30, 0);  cycle();
        set_time(7, 30, 1);
    endtask

    task automatic press(input bit stp, input bit snz);
        stop_btn = stp; snooze_btn = snz; cycle();
        stop_btn = 1'b0; snooze_btn = 1'b0; cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; alarm_en = 1'b0; tick_en = 1'b0;
        settle(2);
        checks++;
        if ({melody_sw, ringing, snoozing, snooze_cnt} !== 7'd0) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", {melody_sw, ringing, snoozing, snooze_cnt}, 7'd0);
        end
        reset = 1'b0; cycle();
        checks++;
        if ({melody_sw, ringing, snoozing, snooze_cnt} !== exp_vec) begin
            errors++; $display("FAIL reset_release: got %b want %b", {melody_sw, ringing, snoozing, snooze_cnt}, exp_vec);
        end
    endtask

    task automatic test_match();
        alarm_en = 1'b1; tick_en = 1'b1;
        set_time(7, 29, 59); settle(3);
        set_time(7, 30, 0); cycle();
        checks++;
        if (melody_sw !== 1'b1) begin
            errors++; $display("FAIL match_fire: melody_sw got %b want 1", melody_sw);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (ringing !== 1'b1 || {melody_sw, ringing, snoozing, snooze_cnt} !== exp_vec) begin
                errors++; $display("FAIL match_hold: cycle %0d got %b want %b", i, {melody_sw, ringing, snoozing, snooze_cnt}, exp_vec);
            end
        end
        set_time(7, 30, 1);
    endtask

    task automatic test_timeout();
        int  ticks;
        bit  t;
        alarm_en = 1'b0; cycle();
        checks++;
        if (ringing !== 1'b0) begin
            errors++; $display("FAIL disable_clears: ringing got %b want 0", ringing);
        end
        alarm_en = 1'b1;
        fire_alarm();
        ticks = 0;
        for (int i = 0; i < 100 && ticks < RING_SEC; i++) begin
            t = tick_1s;
            cycle();
            if (t) ticks++;
            checks++;
            if (melody_sw !== (ticks < RING_SEC) || {melody_sw, ringing, snoozing, snooze_cnt} !== exp_vec) begin
                errors++; $display("FAIL timeout: ticks %0d melody_sw got %b want %b", ticks, melody_sw, ticks < RING_SEC);
            end
        end
        checks++;
        if (ticks != RING_SEC || snooze_cnt !== 4'd0) begin
            errors++; $display("FAIL timeout_end: ticks %0d snooze_cnt %0d want %0d / 0", ticks, snooze_cnt, RING_SEC);
        end
    endtask

    task automatic test_snooze();
        int ticks;
        bit t;
        settle(4);
        fire_alarm();
        settle(2);
        for (int round = 1; round <= MAX_SNOOZE; round++) begin
            press(1'b0, 1'b1);
            checks++;
            if (snoozing !== 1'b1 || melody_sw !== 1'b0 || snooze_cnt !== 4'(round)) begin
                errors++; $display("FAIL snooze_enter: round %0d got sn=%b mel=%b cnt=%0d want 1/0/%0d", round, snoozing, melody_sw, snooze_cnt, round);
            end
            ticks = 0;
            for (int i = 0; i < 60 && ticks < SNOOZE_SEC; i++) begin
                t = tick_1s;
                cycle();
                if (t) ticks++;
                checks++;
                if (snoozing !== (ticks < SNOOZE_SEC) || {melody_sw, ringing, snoozing, snooze_cnt} !== exp_vec) begin
                    errors++; $display("FAIL snooze_wait: ticks %0d got %b want %b", ticks, {melody_sw, ringing, snoozing, snooze_cnt}, exp_vec);
                end
            end
            checks++;
            if (melody_sw !== 1'b1 || ticks != SNOOZE_SEC) begin
                errors++; $display("FAIL snooze_resume: melody_sw %b ticks %0d want 1 / %0d", melody_sw, ticks, SNOOZE_SEC);
            end
        end
        press(1'b0, 1'b1);
        checks++;
        if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 4'(MAX_SNOOZE)) begin
            errors++; $display("FAIL snooze_saturate: ring=%b sn=%b cnt=%0d want 1/0/%0d", ringing, snoozing, snooze_cnt, MAX_SNOOZE);
        end
    endtask

    task automatic test_simultaneous();
        settle(4);
        press(1'b1, 1'b1);
        checks++;
        if ({melody_sw, ringing, snoozing, snooze_cnt} !== 7'd0) begin
            errors++; $display("FAIL stop_and_snooze: got %b want 0", {melody_sw, ringing, snoozing, snooze_cnt});
        end
        settle(4);
        fire_alarm();
        press(1'b0, 1'b1);
        settle(4);
        press(1'b1, 1'b0);
        checks++;
        if ({melody_sw, ringing, snoozing, snooze_cnt} !== 7'd0 || exp_vec !== 7'd0) begin
            errors++; $display("FAIL stop_in_snooze: got %b model %b want 0", {melody_sw, ringing, snoozing, snooze_cnt}, exp_vec);
        end
    endtask

    task automatic test_disable_bounce();
        settle(4);
        fire_alarm();
        alarm_en = 1'b0; cycle();
        checks++;
        if (ringing !== 1'b0 || snooze_cnt !== 4'd0) begin
            errors++; $display("FAIL disable_ring: ringing %b cnt %0d want 0/0", ringing, snooze_cnt);
        end
        alarm_en = 1'b1;
        set_time(7, 29, 59); settle(4);
        stop_btn = 1'b1; cycle();
        set_time(7, 30, 0);
        for (int i = 0; i < 9; i++) begin
            cycle();
            checks++;
            if (ringing !== 1'b1 || {melody_sw, ringing, snoozing, snooze_cnt} !== exp_vec) begin
                errors++; $display("FAIL held_button: cycle %0d ringing %b want 1", i, ringing);
            end
        end
        stop_btn = 1'b0; set_time(7, 30, 1);
        alarm_en = 1'b0; cycle(); alarm_en = 1'b1;
        set_time(7, 29, 59); settle(4);
        stop_btn = 1'b1; cycle();
        stop_btn = 1'b0; set_time(7, 30, 0); cycle();
        stop_btn = 1'b1; cycle();
        stop_btn = 1'b0; set_time(7, 30, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (ringing !== 1'b1 || {melody_sw, ringing, snoozing, snooze_cnt} !== exp_vec) begin
                errors++; $display("FAIL bounce: cycle %0d ringing %b want 1", i, ringing);
            end
        end
    endtask

    task automatic test_reset_snooze();
        alarm_en = 1'b0; cycle(); alarm_en = 1'b1;
        settle(4);
        fire_alarm();
        press(1'b0, 1'b1);
        checks++;
        if (snoozing !== 1'b1 || snooze_cnt !== 4'd1) begin
            errors++; $display("FAIL pre_reset_snooze: sn %b cnt %0d want 1/1", snoozing, snooze_cnt);
        end
        reset = 1'b1; cycle(); reset = 1'b0;
        checks++;
        if ({melody_sw, ringing, snoozing, snooze_cnt} !== 7'd0) begin
            errors++; $display("FAIL reset_mid_snooze: got %b want 0", {melody_sw, ringing, snoozing, snooze_cnt});
        end
        for (int i = 0; i < 15; i++) begin
            cycle();
            checks++;
            if (ringing !== 1'b0 || {melody_sw, ringing, snoozing, snooze_cnt} !== exp_vec) begin
                errors++; $display("FAIL post_reset_idle: cycle %0d got %b want 0", i, {melody_sw, ringing, snoozing, snooze_cnt});
            end
        end
        fire_alarm();
        checks++;
        if (melody_sw !== 1'b1) begin
            errors++; $display("FAIL refire_after_reset: melody_sw %b want 1", melody_sw);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: set_time(7, 30, 0);
                    1: set_time(7, 29, 59);
                    2: set_time(7, 30, 1);
                    default: set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
                endcase
            end
            alarm_en   = ($urandom_range(0, 99) != 0);
            stop_btn   = ($urandom_range(0, 29) == 0);
            snooze_btn = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            cycle();
            checks++;
            if ({melody_sw, ringing, snoozing, snooze_cnt} !== exp_vec) begin
                errors++; $display("FAIL random: cycle %0d got %b want %b", i, {melody_sw, ringing, snoozing, snooze_cnt}, exp_vec);
            end
        end
        reset = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_match();
        test_timeout();
        test_snooze();
        test_simultaneous();
        test_disable_bounce();
        test_reset_snooze();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
